// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared FSM encoding and channel-index width helper for accum_bank
package accum_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } state_t;

    function automatic int ch_width(input int channels);
        return (channels < 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/accum_bank_if.sv
// rtl/accum_bank_if.sv - sample input and dump readout handshake bundle for accum_bank
interface accum_bank_if #(
    parameter int IN_W     = 13,
    parameter int ACC_W    = 21,
    parameter int CHANNELS = 4
) ();
    localparam int CH_W = accum_pkg::ch_width(CHANNELS);

    logic                    ce;
    logic [CH_W-1:0]         ch;
    logic signed [IN_W-1:0]  A;
    logic                    dump;
    logic                    busy;
    logic signed [ACC_W-1:0] Y;
    logic [CH_W-1:0]         y_ch;
    logic                    y_ovf;
    logic                    y_valid;
    logic                    y_ready;

    modport master (
        output ce, ch, A, dump, y_ready,
        input  busy, Y, y_ch, y_ovf, y_valid
    );

    modport slave (
        input  ce, ch, A, dump, y_ready,
        output busy, Y, y_ch, y_ovf, y_valid
    );
endinterface

// File: rtl/accum_bank_sat_add.sv
// rtl/accum_bank_sat_add.sv - signed accumulator + sample add with wrap or saturate and overflow flag
module sat_add #(
    parameter int IN_W  = 13,
    parameter int ACC_W = 21,
    parameter int SAT   = 0
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);
    // One guard bit holds the exact sum since ACC_W >= IN_W.
    logic signed [ACC_W:0] exact;

    assign exact = {a[ACC_W-1], a} + {{(ACC_W + 1 - IN_W){b[IN_W-1]}}, b};
    assign ovf   = exact[ACC_W] != exact[ACC_W-1];

    always_comb begin
        sum = exact[ACC_W-1:0];
        if (SAT != 0 && ovf) begin
            sum = exact[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end
endmodule

// File: rtl/accum_bank.sv
// rtl/accum_bank.sv - bank of signed per-channel accumulators with sticky overflow and sequential dump/clear
module accum_bank
    import accum_pkg::*;
#(
    parameter int IN_W     = 13,
    parameter int ACC_W    = 21,
    parameter int CHANNELS = 4,
    parameter int SAT      = 0
) (
    input  logic         clk,
    input  logic         rst,
    accum_bank_if.slave  bus
);
    localparam int CH_W = ch_width(CHANNELS);

    state_t                  state;
    logic [CH_W-1:0]         k;
    logic signed [ACC_W-1:0] acc [CHANNELS];
    logic [CHANNELS-1:0]     ovf;

    logic                    hs;
    logic                    ch_ok;
    logic                    clr_hit;
    logic signed [ACC_W-1:0] base;
    logic                    base_ovf;
    logic signed [ACC_W-1:0] sum;
    logic                    sum_ovf;

    assign hs      = (state == ST_DUMP) && bus.y_ready;
    assign ch_ok   = 32'(bus.ch) < CHANNELS;
    // A sample landing on the channel being handed off starts from a cleared accumulator.
    assign clr_hit = hs && (bus.ch == k);
    assign base     = clr_hit ? '0 : acc[bus.ch];
    assign base_ovf = clr_hit ? 1'b0 : ovf[bus.ch];

    sat_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_sat_add (
        .a   (base),
        .b   (bus.A),
        .sum (sum),
        .ovf (sum_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            ovf   <= '0;
            state <= ST_IDLE;
            k     <= '0;
        end else begin
            if (hs) begin
                acc[k] <= '0;
                ovf[k] <= 1'b0;
            end
            // Later assignment wins, so a same-cycle sample overrides the clear.
            if (bus.ce && ch_ok) begin
                acc[bus.ch] <= sum;
                ovf[bus.ch] <= base_ovf | sum_ovf;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.dump) begin
                        state <= ST_DUMP;
                        k     <= '0;
                    end
                end
                ST_DUMP: begin
                    if (hs) begin
                        if (k == CH_W'(CHANNELS - 1)) begin
                            state <= ST_IDLE;
                            k     <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    k     <= '0;
                end
            endcase
        end
    end

    assign bus.busy    = (state == ST_DUMP);
    assign bus.y_valid = (state == ST_DUMP);
    assign bus.Y       = (state == ST_DUMP) ? acc[k] : '0;
    assign bus.y_ch    = (state == ST_DUMP) ? k : '0;
    assign bus.y_ovf   = (state == ST_DUMP) ? ovf[k] : 1'b0;
endmodule

// File: tb/tb_accum_bank.sv
// tb/tb_accum_bank.sv - self-checking bench for accum_bank with a behavioural per-cycle model
module tb_accum_bank;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;

    always #5 clk = ~clk;

    accum_bank_if #(.IN_W(13), .ACC_W(21), .CHANNELS(4)) bus ();
    accum_bank_if #(.IN_W(13), .ACC_W(13), .CHANNELS(4)) bus_s ();
    accum_bank_if #(.IN_W(13), .ACC_W(13), .CHANNELS(4)) bus_w ();

    accum_bank #(.IN_W(13), .ACC_W(21), .CHANNELS(4), .SAT(0)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    accum_bank #(.IN_W(13), .ACC_W(13), .CHANNELS(4), .SAT(1)) dut_s (
        .clk (clk), .rst (rst), .bus (bus_s)
    );
    accum_bank #(.IN_W(13), .ACC_W(13), .CHANNELS(4), .SAT(0)) dut_w (
        .clk (clk), .rst (rst), .bus (bus_w)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the main instance: exact integer sums, wrapped to 21 bits.
    longint mdl_acc [4];
    bit     mdl_ovf [4];
    bit     mdl_busy;
    int     mdl_k;
    bit     started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mdl_acc[i] = 0;
                mdl_ovf[i] = 1'b0;
            end
            mdl_busy = 1'b0;
            mdl_k    = 0;
            started  = 1'b1;
        end else if (started) begin
            bit     hs;
            longint s;
            hs = mdl_busy && bus.y_ready;
            if (hs) begin
                mdl_acc[mdl_k] = 0;
                mdl_ovf[mdl_k] = 1'b0;
            end
            if (bus.ce && int'(bus.ch) < 4) begin
                s = mdl_acc[bus.ch] + longint'(bus.A);
                if (s > 1048575 || s < -1048576) begin
                    mdl_ovf[bus.ch] = 1'b1;
                    s = (s + 1048576) % 2097152;
                    if (s < 0) s += 2097152;
                    s -= 1048576;
                end
                mdl_acc[bus.ch] = s;
            end
            if (!mdl_busy && bus.dump) begin
                mdl_busy = 1'b1;
                mdl_k    = 0;
            end else if (hs) begin
                if (mdl_k == 3) mdl_busy = 1'b0;
                else            mdl_k++;
            end
        end
        if (bus.y_valid && bus.y_ready) hs_cnt++;
    end

    always @(negedge clk) begin
        if (started) begin
            check("busy", longint'(bus.busy), longint'(mdl_busy));
            check("y_valid", longint'(bus.y_valid), longint'(mdl_busy));
            if (mdl_busy) begin
                check("model_Y", longint'(bus.Y), mdl_acc[mdl_k]);
                check("model_y_ch", longint'(bus.y_ch), longint'(mdl_k));
                check("model_y_ovf", longint'(bus.y_ovf), longint'(mdl_ovf[mdl_k]));
            end
        end
    end

    task automatic sample(input int c, input int a);
        bus.ce = 1'b1; bus.ch = 2'(c); bus.A = 13'(a);
        @(negedge clk);
        bus.ce = 1'b0;
    endtask

    task automatic pulse_dump();
        bus.dump = 1'b1;
        @(negedge clk);
        bus.dump = 1'b0;
    endtask

    task automatic pop(input int exp_y, input int exp_ch, input int exp_ovf);
        int n = 0;
        while (!bus.y_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.y_valid) begin
            check("pop_timeout", 0, 1);
        end else begin
            check("pop_Y", longint'(bus.Y), longint'(exp_y));
            check("pop_y_ch", longint'(bus.y_ch), longint'(exp_ch));
            check("pop_y_ovf", longint'(bus.y_ovf), longint'(exp_ovf));
            bus.y_ready = 1'b1;
            @(negedge clk);
            bus.y_ready = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_busy", longint'(bus.busy), 0);
    endtask

    task automatic drive13(input logic c, input int chn, input int a, input logic d, input logic r);
        bus_s.ce = c; bus_s.ch = 2'(chn); bus_s.A = 13'(a); bus_s.dump = d; bus_s.y_ready = r;
        bus_w.ce = c; bus_w.ch = 2'(chn); bus_w.A = 13'(a); bus_w.dump = d; bus_w.y_ready = r;
    endtask

    initial begin
        logic [20:0] raw;
        int          snap;
        int          n;
        rst = 1'b1;
        bus.ce = 1'b0; bus.ch = '0; bus.A = '0; bus.dump = 1'b0; bus.y_ready = 1'b0;
        drive13(1'b0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_y_valid", longint'(bus.y_valid), 0);
        check("rst_Y", longint'(bus.Y), 0);
        check("rst_y_ch", longint'(bus.y_ch), 0);
        check("rst_y_ovf", longint'(bus.y_ovf), 0);

        // Basic accumulation on ch0.
        sample(0, 100); sample(0, -30); sample(0, 5);
        pulse_dump();
        pop(75, 0, 0); pop(0, 1, 0); pop(0, 2, 0); pop(0, 3, 0);
        wait_idle();

        // Most negative sample sign-extends.
        sample(2, -4096);
        pulse_dump();
        pop(0, 0, 0); pop(0, 1, 0);
        raw = bus.Y;
        check("y_raw_neg", longint'(raw), longint'(21'h1FF000));
        pop(-4096, 2, 0); pop(0, 3, 0);
        wait_idle();

        // Stall at k=1, then a sample to ch1 in the handshake cycle.
        sample(1, 3);
        pulse_dump();
        pop(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("stall_Y", longint'(bus.Y), 3);
            check("stall_y_ch", longint'(bus.y_ch), 1);
            @(negedge clk);
        end
        bus.y_ready = 1'b1; bus.ce = 1'b1; bus.ch = 2'd1; bus.A = 13'sd7;
        @(negedge clk);
        bus.y_ready = 1'b0; bus.ce = 1'b0;
        pop(0, 2, 0); pop(0, 3, 0);
        wait_idle();
        pulse_dump();
        pop(0, 0, 0); pop(7, 1, 0); pop(0, 2, 0); pop(0, 3, 0);
        wait_idle();

        // Sample and dump together in IDLE: sample lands first.
        bus.ce = 1'b1; bus.ch = 2'd0; bus.A = 13'sd50; bus.dump = 1'b1;
        @(negedge clk);
        bus.ce = 1'b0; bus.dump = 1'b0;
        pop(50, 0, 0); pop(0, 1, 0); pop(0, 2, 0); pop(0, 3, 0);
        wait_idle();

        // Live tracking of Y on a non-handshake sample.
        sample(0, 20);
        pulse_dump();
        check("live_Y_before", longint'(bus.Y), 20);
        sample(0, 10);
        check("live_Y_after", longint'(bus.Y), 30);
        pop(30, 0, 0); pop(0, 1, 0); pop(0, 2, 0); pop(0, 3, 0);
        wait_idle();

        // Dump while busy is ignored.
        sample(3, 9);
        snap = hs_cnt;
        pulse_dump();
        pop(0, 0, 0);
        pulse_dump();
        pop(0, 1, 0); pop(0, 2, 0); pop(9, 3, 0);
        wait_idle();
        repeat (3) @(negedge clk);
        check("hs_count", longint'(hs_cnt - snap), 4);
        check("after_dump_valid", longint'(bus.y_valid), 0);

        // Reset mid-dump at k=2.
        sample(0, 1); sample(1, 2); sample(2, 3); sample(3, 4);
        pulse_dump();
        pop(1, 0, 0); pop(2, 1, 0);
        check("pre_abort_y_ch", longint'(bus.y_ch), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_y_valid", longint'(bus.y_valid), 0);
        repeat (2) @(negedge clk);
        pulse_dump();
        pop(0, 0, 0); pop(0, 1, 0); pop(0, 2, 0); pop(0, 3, 0);
        wait_idle();

        // 13-bit accumulators: saturate vs wrap on 4095 + 1 + 100 into ch1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive13(1'b1, 1, 4095, 1'b0, 1'b0); @(negedge clk);
        drive13(1'b1, 1, 1, 1'b0, 1'b0);    @(negedge clk);
        drive13(1'b1, 1, 100, 1'b0, 1'b0);  @(negedge clk);
        drive13(1'b0, 0, 0, 1'b1, 1'b0);    @(negedge clk);
        drive13(1'b0, 0, 0, 1'b0, 1'b1);
        n = 0;
        while (!(bus_s.y_valid && bus_s.y_ch == 2'd1) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("sat13_reached_ch1", longint'(bus_s.y_valid && bus_s.y_ch == 2'd1), 1);
        check("sat13_Y", longint'(bus_s.Y), 4095);
        check("sat13_y_ovf", longint'(bus_s.y_ovf), 1);
        check("wrap13_Y", longint'(bus_w.Y), -3996);
        check("wrap13_y_ovf", longint'(bus_w.y_ovf), 1);
        repeat (4) @(negedge clk);
        drive13(1'b0, 0, 0, 1'b0, 1'b0);
        check("sat13_idle", longint'(bus_s.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/accum_bank.md
ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 SHALL have parameter IN_W, default 13, meaning signed sample width.
REQ-002 SHALL have parameter ACC_W, default 21, meaning signed accumulator width, ACC_W >= IN_W.
REQ-003 SHALL have parameter CHANNELS, default 4, meaning number of independent accumulators, >= 2.
REQ-004 SHALL have parameter SAT, default 0, meaning 0 = two's-complement wrap, 1 = saturate at signed ACC_W limits.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port ce  input  1  sample valid, one sample per asserted cycle.
REQ-008 SHALL have port ch  input  CH_W = clog2(CHANNELS)  target channel of the sample.
REQ-009 SHALL have port A  input  IN_W  signed sample.
REQ-010 SHALL have port dump  input  1  request to read out and clear all channels.
REQ-011 SHALL have port busy  output  1  high while a dump is in progress.
REQ-012 SHALL have port Y  output  ACC_W  dumped accumulator value.
REQ-013 SHALL have port y_ch  output  CH_W  channel index of Y.
REQ-014 SHALL have port y_ovf  output  1  sticky overflow flag of the dumped channel.
REQ-015 SHALL have ports y_valid output 1 / y_ready input 1  valid/ready handshake for Y, y_ch, y_ovf.

Function
REQ-016 SHALL, when ce=1, set acc[ch] <= acc[ch] + sign_extend(A) at the next edge (latency 1); ce=0 leaves all accumulators unchanged.
REQ-017 SHALL ignore samples whose ch >= CHANNELS (no state change).
REQ-018 SHALL set ovf[ch] when the exact sum leaves [-2^(ACC_W-1), 2^(ACC_W-1)-1]; ovf is sticky until the channel is cleared.
REQ-019 SHALL, with SAT=0, store the ACC_W-bit wrapped sum; with SAT=1, store the nearest limit on overflow and hold it while further samples push the same direction.
REQ-020 SHALL implement FSM IDLE -> DUMP -> IDLE: IDLE with dump=1 enters DUMP with index k=0; dump while busy is ignored.
REQ-021 SHALL, in DUMP, drive y_valid=1, Y=acc[k], y_ch=k, y_ovf=ovf[k]; outputs SHALL stay stable until y_valid && y_ready.
REQ-022 SHALL, on handshake, clear acc[k] and ovf[k] and advance k; handshake with k=CHANNELS-1 returns to IDLE in the next cycle.
REQ-023 SHALL keep accepting samples during DUMP; a sample for channel k in the handshake cycle SHALL make acc[k] = sign_extend(A) (clear then add), ovf[k] set only if that single sample overflows.
REQ-024 SHALL, for a sample to channel k in a non-handshake DUMP cycle, update acc[k]; Y reflects the updated value next cycle (Y tracks live acc[k] until handshake).
REQ-025 SHALL assert busy exactly while in DUMP; y_valid=0 in IDLE.
REQ-026 SHALL treat dump and ce in the same IDLE cycle as: sample applied first, then DUMP starts with the updated values visible at k=0.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, clear all acc and ovf, force IDLE, k=0; outputs Y=0, y_ch=0, y_ovf=0, y_valid=0, busy=0.
REQ-028 SHALL give rst priority over ce, dump and handshake, including mid-dump abort with no further y_valid.

Structure
REQ-029 SHALL place FSM state encoding and the CH_W derivation in shared package accum_pkg.
REQ-030 SHALL use one sub-module, sat_add (IN_W+ACC_W signed add with wrap/saturate and overflow out), instantiated once, shared by the sample path.

Verification
REQ-031 SHALL cover: rst; ch=0 samples 100, -30, 5 -> dump -> Y=75 y_ch=0, then Y=0 for ch=1..3, y_ovf=0.
REQ-032 SHALL cover: A=-4096 (13'h1000) to ch=2 -> dumped Y=21'h1FF000 (-4096), sign extension correct.
REQ-033 SHALL cover: SAT=1, ACC_W=13, ch=1 gets 4095 then 1 -> Y=4095, y_ovf=1; SAT=0 same stimulus -> Y=-4096, y_ovf=1.
REQ-034 SHALL cover: y_ready held 0 for 5 cycles at k=1 -> Y, y_ch stable; sample 7 to ch=1 in handshake cycle -> second dump shows ch1=7.
REQ-035 SHALL cover: rst asserted at k=2 of a dump -> next cycle busy=0, y_valid=0, all channels read 0 in a following dump.
REQ-036 SHALL cover: dump pulsed while busy -> ignored, exactly CHANNELS handshakes occur.
